// File: rtl/cordic_sched.sv
// cordic_sched: round-robin front end for the pipelined CORDIC + Kn datapath.
// Two requesters hand in angles over valid/ready. At most one angle is issued
// per cycle. A valid/tag shift register follows each sample through the
// datapath, and a registered output stage returns the result to its owner.
// The datapath clock enable is the single stall point: when the output is
// full and not being taken, everything upstream freezes together.
module cordic_sched #(
  parameter int W       = 12,
  parameter int LATENCY = 23
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_angle,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_angle,
  output logic         req1_ready,
  output logic         pipe_ce,
  output logic [W-1:0] pipe_angle,
  input  logic [W-1:0] pipe_cos,
  input  logic [W-1:0] pipe_sin,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_id,
  output logic [W-1:0] res_cos,
  output logic [W-1:0] res_sin,
  output logic         busy
);

  // Arbiter state: the requester that won the most recent issue.
  logic               last_grant_q;
  logic               last_grant_d;

  // In-flight tracking: vld marks a live sample in each datapath stage,
  // tag records which requester owns it.
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] vld_d;
  logic [LATENCY-1:0] tag_q;
  logic [LATENCY-1:0] tag_d;

  // Output holding register.
  logic               res_valid_q;
  logic               res_valid_d;
  logic               res_id_q;
  logic               res_id_d;
  logic [W-1:0]       res_cos_q;
  logic [W-1:0]       res_cos_d;
  logic [W-1:0]       res_sin_q;
  logic [W-1:0]       res_sin_d;

  logic               ce;
  logic               any_req;
  logic               grant;
  logic               issue;
  logic               tail_vld;

  // The pipeline advances whenever the output slot is empty or being drained.
  assign ce       = ~res_valid_q | res_ready;
  assign tail_vld = vld_q[LATENCY-1];

  // Round-robin grant: a lone requester always wins; on contention the
  // requester that did not win last time goes first.
  always_comb begin
    any_req      = req0_valid | req1_valid;
    grant        = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
    issue        = ce & any_req;
    last_grant_d = issue ? grant : last_grant_q;
  end

  // Datapath input mux: the granted angle, or zero when nobody asks.
  always_comb begin
    pipe_angle = '0;
    if (any_req) begin
      pipe_angle = grant ? req1_angle : req0_angle;
    end
  end

  // Shift-register next state: stage 0 takes the new issue, every other
  // stage takes its predecessor.
  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_track
    if (gi == 0) begin : g_head
      assign vld_d[gi] = issue;
      assign tag_d[gi] = grant;
    end else begin : g_body
      assign vld_d[gi] = vld_q[gi-1];
      assign tag_d[gi] = tag_q[gi-1];
    end
  end

  // Output register next state: capture the datapath tail on every enabled
  // clock; the data fields only change when the tail carries a live sample.
  always_comb begin
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_cos_d   = res_cos_q;
    res_sin_d   = res_sin_q;
    if (ce) begin
      res_valid_d = tail_vld;
      if (tail_vld) begin
        res_id_d  = tag_q[LATENCY-1];
        res_cos_d = pipe_cos;
        res_sin_d = pipe_sin;
      end
    end
  end

  // Arbiter and in-flight tracker registers; frozen while the pipeline stalls.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      vld_q        <= '0;
      tag_q        <= '0;
    end else if (ce) begin
      last_grant_q <= last_grant_d;
      vld_q        <= vld_d;
      tag_q        <= tag_d;
    end
  end

  // Output holding register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_cos_q   <= '0;
      res_sin_q   <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_cos_q   <= res_cos_d;
      res_sin_q   <= res_sin_d;
    end
  end

  assign req0_ready = issue & ~grant;
  assign req1_ready = issue & grant;
  assign pipe_ce    = ce;
  assign res_valid  = res_valid_q;
  assign res_id     = res_id_q;
  assign res_cos    = res_cos_q;
  assign res_sin    = res_sin_q;
  assign busy       = (|vld_q) | res_valid_q;

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: a stand-in datapath (LATENCY enabled stages and a
// simple cos/sin mapping), a transaction-level reference model compared on
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_cordic_sched;
  localparam int W = 12;
  localparam int L = 23;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         req0_valid;
  logic [W-1:0] req0_angle;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_angle;
  logic         req1_ready;
  logic         pipe_ce;
  logic [W-1:0] pipe_angle;
  logic [W-1:0] pipe_cos;
  logic [W-1:0] pipe_sin;
  logic         res_valid;
  logic         res_ready;
  logic         res_id;
  logic [W-1:0] res_cos;
  logic [W-1:0] res_sin;
  logic         busy;

  always #5 clock = ~clock;

  cordic_sched #(.W(W), .LATENCY(L)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_angle (req0_angle),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_angle (req1_angle),
    .req1_ready (req1_ready),
    .pipe_ce    (pipe_ce),
    .pipe_angle (pipe_angle),
    .pipe_cos   (pipe_cos),
    .pipe_sin   (pipe_sin),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_cos    (res_cos),
    .res_sin    (res_sin),
    .busy       (busy)
  );

  // Stand-in datapath transfer functions; angle 0 gives cos = 1.0 (0x400).
  function automatic logic [W-1:0] f_cos(input logic [W-1:0] a);
    return (a == '0) ? 12'h400 : (a ^ 12'hA5A);
  endfunction
  function automatic logic [W-1:0] f_sin(input logic [W-1:0] a);
    return a + 12'h123;
  endfunction

  // Stand-in datapath: L clock-enabled stages.
  logic [W-1:0] dp [L];
  initial for (int i = 0; i < L; i++) dp[i] = '0;
  always @(posedge clock) begin
    if (pipe_ce) begin
      dp[0] <= pipe_angle;
      for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
    end
  end
  assign pipe_cos = f_cos(dp[L-1]);
  assign pipe_sin = f_sin(dp[L-1]);

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic armed   = 1'b0;
  logic verbose = 1'b0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (!reset_n) armed <= 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an ordered list of issued samples, each stamped with the
  // enable-edge count at which it was accepted; it must emerge exactly L
  // enabled edges later.
  typedef struct packed {
    logic         id;
    logic [W-1:0] ang;
    int           stamp;
  } item_t;
  item_t        inflight[$];
  int           ce_edges = 0;
  logic         m_lg  = 1'b1;
  logic         m_rv  = 1'b0;
  logic         m_id  = 1'b0;
  logic [W-1:0] m_cos = '0;
  logic [W-1:0] m_sin = '0;
  logic         log_id[$];
  int           log_cyc[$];

  // Compare on the falling edge, then advance the model by the coming edge.
  always @(negedge clock) begin
    logic         ce_e;
    logic         g_any;
    logic         g;
    logic [W-1:0] ang_e;
    item_t        it;
    ce_e  = !m_rv || res_ready;
    g_any = req0_valid || req1_valid;
    g     = (req0_valid && req1_valid) ? !m_lg : req1_valid;
    ang_e = !g_any ? '0 : (g ? req1_angle : req0_angle);
    if (armed) begin
      chk("pipe_ce",    32'(pipe_ce),    32'(ce_e));
      chk("req0_ready", 32'(req0_ready), 32'(ce_e && g_any && !g));
      chk("req1_ready", 32'(req1_ready), 32'(ce_e && g_any && g));
      chk("pipe_angle", 32'(pipe_angle), 32'(ang_e));
      chk("res_valid",  32'(res_valid),  32'(m_rv));
      chk("busy",       32'(busy),       32'((inflight.size() != 0) || m_rv));
      if (m_rv) begin
        chk("res_id",  32'(res_id),  32'(m_id));
        chk("res_cos", 32'(res_cos), 32'(m_cos));
        chk("res_sin", 32'(res_sin), 32'(m_sin));
      end
      if (res_valid && res_ready && reset_n) begin
        log_id.push_back(res_id);
        log_cyc.push_back(cyc);
        if (verbose)
          $display("result id=%0d cos=0x%03h sin=0x%03h cycle=%0d", res_id, res_cos, res_sin, cyc);
      end
    end
    if (!reset_n) begin
      inflight.delete();
      m_rv = 1'b0;
      m_lg = 1'b1;
    end else if (ce_e) begin
      ce_edges++;
      if (inflight.size() > 0 && (ce_edges - inflight[0].stamp) == L) begin
        it    = inflight.pop_front();
        m_rv  = 1'b1;
        m_id  = it.id;
        m_cos = f_cos(it.ang);
        m_sin = f_sin(it.ang);
      end else begin
        m_rv = 1'b0;
      end
      if (g_any) begin
        it.id    = g;
        it.ang   = ang_e;
        it.stamp = ce_edges;
        inflight.push_back(it);
        m_lg = g;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_angle = '0;
    req1_angle = '0;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    res_ready = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset_n = 1'b1;
    log_id.delete();
    log_cyc.delete();
  endtask

  initial begin
    int           start;
    logic         found;
    logic         alt_ok;
    logic [W-1:0] cap_cos;
    logic [W-1:0] cap_sin;

    reset_n   = 1'b0;
    res_ready = 1'b1;
    idle_inputs();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    verbose = 1'b1;

    // Reset state.
    @(negedge clock);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    tick();

    // Single angle 0 from requester 0: latency and value.
    req0_valid = 1'b1;
    req0_angle = 12'h000;
    @(negedge clock);
    chk("t1_ready0", 32'(req0_ready), 32'd1);
    start = cyc;
    tick();
    req0_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (res_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("t1_result_seen", 32'(found), 32'd1);
    chk("t1_latency",     32'(cyc - start), 32'd24);
    chk("t1_res_id",      32'(res_id),  32'd0);
    chk("t1_res_cos",     32'(res_cos), 32'h400);
    chk("t1_res_sin",     32'(res_sin), 32'h123);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("t1_busy_after_take", 32'(busy), 32'd0);
    tick();

    // Both requesters held for 8 cycles: grants alternate starting with 0.
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req0_angle = W'($urandom);
      req1_angle = W'($urandom);
      @(negedge clock);
      chk("t2_grant1", 32'(req1_ready), 32'(i % 2));
      chk("t2_grant0", 32'(req0_ready), 32'((i + 1) % 2));
      tick();
    end
    idle_inputs();
    repeat (40) tick();
    chk("t2_count", 32'(log_id.size()), 32'd8);
    alt_ok = (log_id.size() == 8);
    foreach (log_id[i]) if (log_id[i] != 1'(i % 2)) alt_ok = 1'b0;
    chk("t2_id_order", 32'(alt_ok), 32'd1);

    // 30 back-to-back angles from requester 1.
    do_reset();
    req1_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      req1_angle = W'(i * 37 + 5);
      @(negedge clock);
      chk("t3_ready1", 32'(req1_ready), 32'd1);
      tick();
    end
    idle_inputs();
    repeat (40) tick();
    chk("t3_count", 32'(log_id.size()), 32'd30);
    alt_ok = (log_id.size() == 30);
    foreach (log_id[i]) if (log_id[i] != 1'b1) alt_ok = 1'b0;
    chk("t3_all_id1", 32'(alt_ok), 32'd1);
    if (log_cyc.size() == 30)
      chk("t3_consecutive", 32'(log_cyc[29] - log_cyc[0]), 32'd29);

    // Full pipeline, output blocked for 5 cycles.
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      req0_angle = W'($urandom);
      req1_angle = W'($urandom);
      tick();
    end
    res_ready = 1'b0;
    cap_cos   = '0;
    cap_sin   = '0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clock);
      if (s == 0) begin
        chk("t4_res_valid", 32'(res_valid), 32'd1);
        cap_cos = res_cos;
        cap_sin = res_sin;
      end
      chk("t4_ce_low",   32'(pipe_ce),    32'd0);
      chk("t4_ready0",   32'(req0_ready), 32'd0);
      chk("t4_ready1",   32'(req1_ready), 32'd0);
      chk("t4_cos_hold", 32'(res_cos),    32'(cap_cos));
      chk("t4_sin_hold", 32'(res_sin),    32'(cap_sin));
      tick();
    end
    res_ready = 1'b1;
    idle_inputs();
    repeat (40) tick();
    chk("t4_count", 32'(log_id.size()), 32'd30);
    alt_ok = (log_id.size() == 30);
    foreach (log_id[i]) if (log_id[i] != 1'(i % 2)) alt_ok = 1'b0;
    chk("t4_id_order", 32'(alt_ok), 32'd1);

    // Reset with 10 samples in flight.
    do_reset();
    req0_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req0_angle = W'($urandom);
      tick();
    end
    idle_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clock);
    chk("t5_res_valid", 32'(res_valid), 32'd0);
    chk("t5_busy",      32'(busy),      32'd0);
    for (int i = 0; i < 30; i++) begin
      tick();
      @(negedge clock);
      chk("t5_no_stale", 32'(res_valid), 32'd0);
    end
    tick();

    // Lone requester 1 regranted immediately; then contention goes to 0.
    do_reset();
    req1_valid = 1'b1;
    req1_angle = 12'h0AA;
    @(negedge clock);
    chk("t6_first",  32'(req1_ready), 32'd1);
    tick();
    req1_angle = 12'h0BB;
    @(negedge clock);
    chk("t6_second", 32'(req1_ready), 32'd1);
    tick();
    req0_valid = 1'b1;
    req0_angle = 12'h0CC;
    @(negedge clock);
    chk("t6_contend0", 32'(req0_ready), 32'd1);
    tick();
    idle_inputs();
    repeat (40) tick();
    verbose = 1'b0;

    // Random traffic with backpressure, abandoned requests and rare resets.
    for (int i = 0; i < 3000; i++) begin
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 50);
      req0_angle = W'($urandom);
      req1_angle = W'($urandom);
      res_ready  = ($urandom_range(0, 99) < 70);
      reset_n    = ($urandom_range(0, 499) != 0);
      tick();
    end
    reset_n   = 1'b1;
    res_ready = 1'b1;
    idle_inputs();
    repeat (40) tick();
    @(negedge clock);
    chk("drain_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
